pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter CNT_W, default 32, width of every performance counter.
REQ-002 Parameter WDOG_CYCLES, default 1000, cycle budget before the watchdog trips; 0 disables the watchdog.
REQ-003 Parameter RNONE, default 4'hF, register ID meaning "no register".
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 run_en  input  1  1 = pipeline advances, 0 = freeze (single-step/debug hold).
REQ-007 D_icode, E_icode, M_icode  input  4 each  icode held in the D, E and M pipeline registers.
REQ-008 E_dstM  input  4  E-stage memory destination register.
REQ-009 d_srcA, d_srcB  input  4 each  decode-stage source register IDs.
REQ-010 e_Cnd  input  1  condition outcome for the instruction in the E stage.
REQ-011 m_stat, W_stat  input  3 each  status: 1=AOK, 2=HLT, 3=ADR, 4=INS.
REQ-012 W_icode  input  4  icode in the W register; 4'h1 (NOP) marks a bubble.
REQ-013 F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall  output  1 each  pipeline-register controls.
REQ-014 proc_stat  output  3  registered processor status, same encoding as REQ-011.
REQ-015 state  output  2  0=IDLE, 1=RUN, 2=HALTED, 3=FAULT.
REQ-016 cyc_cnt, ret_cnt, stall_cnt, bub_cnt  output  CNT_W each  cycles in RUN; retired instructions; load-use/ret stall cycles; mispredict bubbles.

Function
REQ-017 Hazard terms are combinational:
  - lu = (E_icode==5 or E_icode==B) and E_dstM!=RNONE and E_dstM is d_srcA or d_srcB.
  - rt = 9 appears in D_icode, E_icode or M_icode.
  - mp = E_icode==7 and e_Cnd==0.
  - exc_m = m_stat is 2, 3 or 4.
  - exc_w = W_stat is 2, 3 or 4.
REQ-018 In state RUN with run_en=1, the control outputs are:
  - F_stall = lu|rt
  - D_stall = lu
  - D_bubble = mp | (rt & ~lu)
  - E_bubble = mp | lu
  - M_bubble = exc_m | exc_w
  - W_stall = exc_w
REQ-019 In any state other than RUN, or when run_en=0, F_stall=D_stall=W_stall=1 and all bubble outputs are 0.
REQ-020 A D_stall and a D_bubble in the same cycle are never both asserted; D_stall has priority.
REQ-021 State transitions:
  - IDLE->RUN on the first edge after reset release.
  - RUN->HALTED when W_stat==2.
  - RUN->FAULT when W_stat is 3 or 4, or when the watchdog expires.
  - HALTED and FAULT are left only by reset.
REQ-022 proc_stat captures W_stat on the RUN->HALTED/FAULT edge and holds it. A watchdog fault sets proc_stat=3. While in RUN, proc_stat=1.
REQ-023 cyc_cnt increments on each edge in RUN with run_en=1.
REQ-024 The watchdog trips on the edge where cyc_cnt would reach WDOG_CYCLES.
REQ-025 ret_cnt increments when RUN, run_en=1, W_stat==1 and W_icode!=1.
REQ-026 stall_cnt increments when RUN, run_en=1 and (lu|rt) is high.
REQ-027 bub_cnt increments when RUN, run_en=1 and mp is high.
REQ-028 All counters saturate at 2^CNT_W-1; they do not wrap.
REQ-029 When a transition edge and a counter increment coincide, the increment is applied and the state still changes.
REQ-030 Counters and state are frozen while run_en=0; resuming continues with no lost or duplicated counts.

Reset
REQ-031 On a rising edge with rst_n=0:
  - state=IDLE
  - proc_stat=1
  - all counters = 0
  - the watchdog is cleared
REQ-032 Reset takes effect at the next edge regardless of state, including mid-stall and HALTED/FAULT; the control outputs follow REQ-019 that cycle.

Verification
REQ-033 Load-use: E_icode=5, E_dstM=3, d_srcA=3, RUN -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; stall_cnt +1.
REQ-034 Mispredict: E_icode=7, e_Cnd=0, D_icode=9 -> D_bubble=1, E_bubble=1, F_stall=1; bub_cnt +1.
REQ-035 Halt: W_stat=2 in RUN -> W_stall=1 that cycle; next edge state=2, proc_stat=2; cyc_cnt frozen afterwards.
REQ-036 Address fault: m_stat=3 -> M_bubble=1; then W_stat=3 -> state=3, proc_stat=3.
REQ-037 Watchdog: WDOG_CYCLES=16, all stats AOK -> state=3, proc_stat=3, cyc_cnt=16.
REQ-038 Freeze and reset: run_en=0 for 5 cycles mid-run -> counters unchanged; rst_n=0 while in FAULT -> IDLE, all counters 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller for a five-stage Y86-style core.
// Drives stall/bubble controls, a run-state FSM and saturating perf counters.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   run_en                      1 = advance, 0 = freeze everything
//   D_icode, E_icode, M_icode   icodes held in the D/E/M pipeline registers
//   E_dstM                      E-stage memory destination register
//   d_srcA, d_srcB              decode-stage source registers
//   e_Cnd                       E-stage condition outcome
//   m_stat, W_stat              stage status (1 AOK, 2 HLT, 3 ADR, 4 INS)
//   W_icode                     W-register icode (NOP = bubble)
//   F_stall..W_stall            pipeline-register controls
//   proc_stat                   registered processor status
//   state                       0 IDLE, 1 RUN, 2 HALTED, 3 FAULT
//   cyc_cnt, ret_cnt,
//   stall_cnt, bub_cnt          saturating performance counters

module pipe_ctrl #(
    parameter int         CNT_W       = 32,
    parameter int         WDOG_CYCLES = 1000,
    parameter logic [3:0] RNONE       = 4'hF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_en,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       E_dstM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic             e_Cnd,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    input  logic [3:0]       W_icode,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic [2:0]       proc_stat,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bub_cnt
);

    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_POPQ  = 4'hB;

    localparam logic [2:0] ST_AOK = 3'd1;
    localparam logic [2:0] ST_HLT = 3'd2;
    localparam logic [2:0] ST_ADR = 3'd3;
    localparam logic [2:0] ST_INS = 3'd4;

    // The watchdog has its own counter so that a narrow CNT_W (which
    // saturates early) can never hide the trip point.
    localparam int WD_W = (WDOG_CYCLES < 2) ? 1
                                            : $clog2(WDOG_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_FAULT = 2'd3
    } fsm_t;

    fsm_t            fsm;
    logic [WD_W-1:0] wd_cnt;

    logic lu;
    logic rt;
    logic mp;
    logic exc_m;
    logic exc_w;
    logic active;
    logic wd_trip;

    function automatic logic is_exc(input logic [2:0] s);
        return (s == ST_HLT) || (s == ST_ADR) || (s == ST_INS);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Hazard detection
    always_comb begin
        lu = ((E_icode == I_MRMOV) || (E_icode == I_POPQ))
             && (E_dstM != RNONE)
             && ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        rt = (D_icode == I_RET) || (E_icode == I_RET)
             || (M_icode == I_RET);
        mp = (E_icode == I_JXX) && !e_Cnd;
        exc_m = is_exc(m_stat);
        exc_w = is_exc(W_stat);
    end

    assign active  = (fsm == S_RUN) && run_en;
    assign wd_trip = (WDOG_CYCLES != 0)
                     && (wd_cnt == WD_W'(WDOG_CYCLES - 1));

    // Pipeline-register controls. Outside an active RUN cycle the
    // pipeline is held with no bubbles injected.
    always_comb begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b1;
        if (active) begin
            F_stall  = lu | rt;
            D_stall  = lu;
            // A stalled D register must not also be bubbled.
            D_bubble = (mp | (rt & ~lu)) & ~lu;
            E_bubble = mp | lu;
            M_bubble = exc_m | exc_w;
            W_stall  = exc_w;
        end
    end

    // Run-state FSM, status capture, counters and watchdog
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm       <= S_IDLE;
            proc_stat <= ST_AOK;
            cyc_cnt   <= '0;
            ret_cnt   <= '0;
            stall_cnt <= '0;
            bub_cnt   <= '0;
            wd_cnt    <= '0;
        end else begin
            unique case (fsm)
                S_IDLE: fsm <= S_RUN;
                S_RUN: begin
                    if (run_en) begin
                        cyc_cnt <= sat_inc(cyc_cnt);
                        if ((W_stat == ST_AOK) && (W_icode != I_NOP))
                            ret_cnt <= sat_inc(ret_cnt);
                        if (lu | rt)
                            stall_cnt <= sat_inc(stall_cnt);
                        if (mp)
                            bub_cnt <= sat_inc(bub_cnt);
                        if (WDOG_CYCLES != 0)
                            wd_cnt <= wd_cnt + WD_W'(1);
                        // A retiring exception outranks a coincident
                        // watchdog trip so its status is kept.
                        if (exc_w) begin
                            fsm <= (W_stat == ST_HLT) ? S_HALT : S_FAULT;
                            proc_stat <= W_stat;
                        end else if (wd_trip) begin
                            fsm       <= S_FAULT;
                            proc_stat <= ST_ADR;
                        end
                    end
                end
                S_HALT:  fsm <= S_HALT;
                S_FAULT: fsm <= S_FAULT;
                default: fsm <= S_FAULT;
            endcase
        end
    end

    assign state = fsm;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed vectors push expected
// outputs; a negedge monitor pops and compares.

module tb_pipe_ctrl;

    localparam logic [5:0] CT_NONE = 6'b000000;
    localparam logic [5:0] CT_HOLD = 6'b110001;
    localparam logic [5:0] CT_LU   = 6'b110100;
    localparam logic [5:0] CT_MP   = 6'b101100;
    localparam logic [5:0] CT_RT   = 6'b101000;
    localparam logic [5:0] CT_MEX  = 6'b000010;
    localparam logic [5:0] CT_WEX  = 6'b000011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run_en;
    logic [3:0]  D_icode, E_icode, M_icode, E_dstM;
    logic [3:0]  d_srcA, d_srcB, W_icode;
    logic        e_Cnd;
    logic [2:0]  m_stat, W_stat;

    logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
    logic [2:0]  proc_stat;
    logic [1:0]  state;
    logic [31:0] cyc_cnt, ret_cnt, stall_cnt, bub_cnt;

    logic        F_stall2, D_stall2, D_bubble2, E_bubble2;
    logic        M_bubble2, W_stall2;
    logic [2:0]  proc_stat2;
    logic [1:0]  state2;
    logic [3:0]  cyc_cnt2, ret_cnt2, stall_cnt2, bub_cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [5:0]  ct;
        logic [1:0]  st;
        logic [2:0]  ps;
        logic [31:0] cyc;
        logic [31:0] ret;
        logic [31:0] stl;
        logic [31:0] bub;
        bit          c2;
        logic [1:0]  st2;
        logic [3:0]  cyc2;
        logic [3:0]  ret2;
    } exp_t;

    exp_t  sb_q[$];
    string nm_q[$];

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(32), .WDOG_CYCLES(16), .RNONE(4'hF)) u_dut (
        .clk(clk), .rst_n(rst_n), .run_en(run_en),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
        .E_dstM(E_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .e_Cnd(e_Cnd), .m_stat(m_stat), .W_stat(W_stat),
        .W_icode(W_icode),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .proc_stat(proc_stat), .state(state),
        .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt),
        .stall_cnt(stall_cnt), .bub_cnt(bub_cnt)
    );

    // Narrow counters, watchdog disabled: exercises saturation.
    pipe_ctrl #(.CNT_W(4), .WDOG_CYCLES(0), .RNONE(4'hF)) u_sat (
        .clk(clk), .rst_n(rst_n), .run_en(run_en),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
        .E_dstM(E_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .e_Cnd(e_Cnd), .m_stat(m_stat), .W_stat(W_stat),
        .W_icode(W_icode),
        .F_stall(F_stall2), .D_stall(D_stall2), .D_bubble(D_bubble2),
        .E_bubble(E_bubble2), .M_bubble(M_bubble2), .W_stall(W_stall2),
        .proc_stat(proc_stat2), .state(state2),
        .cyc_cnt(cyc_cnt2), .ret_cnt(ret_cnt2),
        .stall_cnt(stall_cnt2), .bub_cnt(bub_cnt2)
    );

    function automatic void check(string nm, string fld,
                                  logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s actual=%0h required=%0h",
                     nm, fld, act, exp);
        end
    endfunction

    // Monitor: compare one expected record per cycle when present
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t  e;
            string n;
            e = sb_q.pop_front();
            n = nm_q.pop_front();
            check(n, "ctrl",
                  32'({F_stall, D_stall, D_bubble,
                       E_bubble, M_bubble, W_stall}), 32'(e.ct));
            check(n, "state", 32'(state), 32'(e.st));
            check(n, "proc_stat", 32'(proc_stat), 32'(e.ps));
            check(n, "cyc_cnt", cyc_cnt, e.cyc);
            check(n, "ret_cnt", ret_cnt, e.ret);
            check(n, "stall_cnt", stall_cnt, e.stl);
            check(n, "bub_cnt", bub_cnt, e.bub);
            if (e.c2) begin
                check(n, "sat_ctrl",
                      32'({F_stall2, D_stall2, D_bubble2,
                           E_bubble2, M_bubble2, W_stall2}),
                      32'(CT_NONE));
                check(n, "sat_state", 32'(state2), 32'(e.st2));
                check(n, "sat_proc", 32'(proc_stat2), 32'd1);
                check(n, "sat_cyc", 32'(cyc_cnt2), 32'(e.cyc2));
                check(n, "sat_ret", 32'(ret_cnt2), 32'(e.ret2));
                check(n, "sat_stall", 32'(stall_cnt2), 32'd0);
                check(n, "sat_bub", 32'(bub_cnt2), 32'd0);
            end
        end
    end

    task automatic go(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string nm, input logic [5:0] ct,
                              input logic [1:0] st, input logic [2:0] ps,
                              input int cyc, input int ret,
                              input int stl, input int bub,
                              input bit c2 = 1'b0,
                              input logic [1:0] st2 = 2'd0,
                              input int cyc2 = 0, input int ret2 = 0);
        exp_t e;
        e.ct = ct; e.st = st; e.ps = ps;
        e.cyc = 32'(cyc); e.ret = 32'(ret);
        e.stl = 32'(stl); e.bub = 32'(bub);
        e.c2 = c2; e.st2 = st2;
        e.cyc2 = 4'(cyc2); e.ret2 = 4'(ret2);
        sb_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic idle_in();
        run_en  = 1'b1;
        D_icode = 4'h0; E_icode = 4'h0; M_icode = 4'h0;
        E_dstM  = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF;
        e_Cnd   = 1'b1;
        m_stat  = 3'd1; W_stat = 3'd1; W_icode = 4'h1;
    endtask

    task automatic set_lu(input logic [3:0] ic, input logic [3:0] r);
        E_icode = ic; E_dstM = r; d_srcA = r;
    endtask

    // Reset, then one edge into RUN with all counters at zero
    task automatic start();
        rst_n = 1'b0;
        idle_in();
        go(2);
        rst_n = 1'b1;
        go(1);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_in();
        go(2);
        expect_now("reset", CT_HOLD, 2'd0, 3'd1, 0, 0, 0, 0);
        go(1);

        // Hazard sweep
        start();
        expect_now("run0", CT_NONE, 2'd1, 3'd1, 0, 0, 0, 0);
        go(1);
        set_lu(4'h5, 4'h3);
        expect_now("lu_srcA", CT_LU, 2'd1, 3'd1, 1, 0, 0, 0);
        go(1);
        idle_in();
        E_icode = 4'hB; E_dstM = 4'h4; d_srcB = 4'h4;
        expect_now("lu_srcB", CT_LU, 2'd1, 3'd1, 2, 0, 1, 0);
        go(1);
        idle_in();
        E_icode = 4'h5;
        expect_now("lu_rnone", CT_NONE, 2'd1, 3'd1, 3, 0, 2, 0);
        go(1);
        idle_in();
        E_icode = 4'h7; e_Cnd = 1'b0; D_icode = 4'h9;
        expect_now("mispred", CT_MP, 2'd1, 3'd1, 4, 0, 2, 0);
        go(1);
        idle_in();
        M_icode = 4'h9;
        expect_now("ret_m", CT_RT, 2'd1, 3'd1, 5, 0, 3, 1);
        go(1);
        set_lu(4'h5, 4'h3);
        expect_now("lu_ret", CT_LU, 2'd1, 3'd1, 6, 0, 4, 1);
        go(1);
        idle_in();
        E_icode = 4'h7;
        expect_now("jmp_taken", CT_NONE, 2'd1, 3'd1, 7, 0, 5, 1);
        go(1);
        idle_in();
        W_icode = 4'h0;
        expect_now("retire0", CT_NONE, 2'd1, 3'd1, 8, 0, 5, 1);
        go(1);
        expect_now("retire1", CT_NONE, 2'd1, 3'd1, 9, 1, 5, 1);
        go(1);

        // Freeze with hazards, retire and halt all presented
        run_en = 1'b0;
        set_lu(4'h5, 4'h3);
        W_stat = 3'd2;
        expect_now("frz", CT_HOLD, 2'd1, 3'd1, 10, 2, 5, 1);
        go(5);
        expect_now("frz_hold", CT_HOLD, 2'd1, 3'd1, 10, 2, 5, 1);
        go(1);
        idle_in();
        expect_now("resume", CT_NONE, 2'd1, 3'd1, 10, 2, 5, 1);
        go(1);

        // Address fault through M then W
        m_stat = 3'd3;
        expect_now("exc_m", CT_MEX, 2'd1, 3'd1, 11, 2, 5, 1);
        go(1);
        m_stat = 3'd1; W_stat = 3'd3;
        expect_now("exc_w", CT_WEX, 2'd1, 3'd1, 12, 2, 5, 1);
        go(1);
        idle_in();
        expect_now("fault", CT_HOLD, 2'd3, 3'd3, 13, 2, 5, 1);
        go(3);
        expect_now("fault_hold", CT_HOLD, 2'd3, 3'd3, 13, 2, 5, 1);
        set_lu(4'h5, 4'h3);
        rst_n = 1'b0;
        go(1);
        expect_now("rst_fault", CT_HOLD, 2'd0, 3'd1, 0, 0, 0, 0);
        go(1);

        // Halt
        start();
        W_stat = 3'd2;
        expect_now("halt_w", CT_WEX, 2'd1, 3'd1, 0, 0, 0, 0);
        go(1);
        idle_in();
        expect_now("halted", CT_HOLD, 2'd2, 3'd2, 1, 0, 0, 0);
        go(3);
        expect_now("halt_frz", CT_HOLD, 2'd2, 3'd2, 1, 0, 0, 0);
        go(1);

        // Illegal instruction
        start();
        W_stat = 3'd4; W_icode = 4'h0;
        expect_now("ins_w", CT_WEX, 2'd1, 3'd1, 0, 0, 0, 0);
        go(1);
        idle_in();
        expect_now("ins_flt", CT_HOLD, 2'd3, 3'd4, 1, 0, 0, 0);
        go(1);

        // Watchdog at 16 cycles; narrow instance saturates instead
        start();
        W_icode = 4'h0;
        go(15);
        expect_now("wd_pre", CT_NONE, 2'd1, 3'd1, 15, 15, 0, 0,
                   1'b1, 2'd1, 15, 15);
        go(1);
        expect_now("wd_trip", CT_HOLD, 2'd3, 3'd3, 16, 16, 0, 0,
                   1'b1, 2'd1, 15, 15);
        go(3);
        expect_now("wd_hold", CT_HOLD, 2'd3, 3'd3, 16, 16, 0, 0,
                   1'b1, 2'd1, 15, 15);
        go(2);

        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
